// File: rtl/watchdog_reset_gen_pkg.sv
// Shared types and constants for the watchdog reset generator.
package watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } wd_state_e;

  localparam int unsigned TRIP_W   = 8;
  localparam int unsigned TRIP_MAX = 255;

endpackage

// File: rtl/watchdog_reset_gen_if.sv
// Control/status bundle between a supervisor and the watchdog.
// master: the supervisor (drives enable/kick); slave: the watchdog.
interface watchdog_reset_gen_if;
  import watchdog_pkg::*;

  logic              enable;
  logic              kick;
  logic              rst_req;
  logic              warn;
  logic [TRIP_W-1:0] trip_count;

  modport master (output enable, output kick,
                  input  rst_req, input warn, input trip_count);
  modport slave  (input  enable, input kick,
                  output rst_req, output warn, output trip_count);
endinterface

// File: rtl/watchdog_reset_gen_sat_counter.sv
// Width-parameterised up-counter that sticks at MAX; clear and reset zero it.
module sat_counter #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] CNT_MAX = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + W'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/watchdog_reset_gen.sv
// Watchdog that raises a PULSE_LEN-cycle reset request when not kicked
// within TIMEOUT cycles. rst_in must come from the upstream reset, never
// from the delayed reset that rst_req produces.
// Optional feature macro: WATCHDOG_WARN_EN (early-warning flag).
module watchdog_reset_gen
  import watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 32'd1000000,
  parameter int unsigned PULSE_LEN   = 32'd16,
  parameter int unsigned WARN_MARGIN = 32'd1000,
  parameter int unsigned LEN_LOG     = 32
) (
  input  logic                clk,
  input  logic                rst_in,
  watchdog_reset_gen_if.slave wd
);
  localparam logic [LEN_LOG-1:0] CNT_LAST  = LEN_LOG'(TIMEOUT - 1);
  localparam logic [LEN_LOG-1:0] PCNT_LAST = LEN_LOG'(PULSE_LEN - 1);

  // Reject parameter sets that would make the window or pulse meaningless.
  if (TIMEOUT < 2)             begin : g_bad_timeout $error("TIMEOUT must be >= 2"); end
  if (PULSE_LEN < 1)           begin : g_bad_pulse   $error("PULSE_LEN must be >= 1"); end
  if (WARN_MARGIN >= TIMEOUT)  begin : g_bad_margin  $error("WARN_MARGIN must be < TIMEOUT"); end

  wd_state_e          state_q, state_d;
  logic [LEN_LOG-1:0] cnt_q, cnt_d;
  logic [LEN_LOG-1:0] pcnt_q, pcnt_d;
  logic               rst_req_q, rst_req_d;
  logic               trip_inc;

  // Next-state decode: window counting in ARMED, pulse timing in FIRE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    rst_req_d = rst_req_q;
    trip_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rst_req_d = 1'b0;
        if (wd.enable) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (!wd.enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wd.kick) begin
          cnt_d = '0;               // a kick on the timeout edge still saves us
        end else if (cnt_q == CNT_LAST) begin
          state_d   = FIRE;
          rst_req_d = 1'b1;
          pcnt_d    = '0;
          trip_inc  = 1'b1;
        end else begin
          cnt_d = cnt_q + LEN_LOG'(1);
        end
      end
      FIRE: begin
        // Kick and enable cannot shorten the pulse once started.
        rst_req_d = 1'b1;
        if (pcnt_q == PCNT_LAST) begin
          rst_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = wd.enable ? ARMED : IDLE;
        end else begin
          pcnt_d = pcnt_q + LEN_LOG'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rst_req_d = 1'b0;
      end
    endcase
  end

  // State and counter registers; rst_in overrides everything, mid-pulse too.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      rst_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      rst_req_q <= rst_req_d;
    end
  end

  sat_counter #(
    .W   (TRIP_W),
    .MAX (TRIP_MAX)
  ) u_trip_cnt (
    .clk   (clk),
    .rst   (rst_in),
    .clr_i (1'b0),
    .inc_i (trip_inc),
    .cnt_o (wd.trip_count)
  );

  assign wd.rst_req = rst_req_q;

`ifdef WATCHDOG_WARN_EN
  localparam logic [LEN_LOG-1:0] WARN_TH = LEN_LOG'(TIMEOUT - WARN_MARGIN);
  assign wd.warn = (state_q == ARMED) && (cnt_q >= WARN_TH);
`else
  assign wd.warn = 1'b0;
`endif

endmodule

// File: tb/tb_watchdog_reset_gen.sv
// Self-checking bench for watchdog_reset_gen (TIMEOUT=8, PULSE_LEN=3, WARN_MARGIN=2).
module tb_watchdog_reset_gen;
  localparam int T = 8;
  localparam int P = 3;
  localparam int M = 2;

  typedef struct packed {
    logic       req;
    logic       warn;
    logic [7:0] trip;
  } exp_t;

  logic clk = 1'b0;
  logic rst_in;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference state, written only by tick().
  int   m_st = 0;
  int   m_cnt = 0;
  int   m_pcnt = 0;
  logic m_req = 1'b0;
  int   m_trip = 0;

  watchdog_reset_gen_if wd ();

  watchdog_reset_gen #(
    .TIMEOUT     (T),
    .PULSE_LEN   (P),
    .WARN_MARGIN (M),
    .LEN_LOG     (32)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .wd     (wd.slave)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs, push the expected post-edge outputs, cross the edge.
  task automatic tick(input logic r, input logic en, input logic k);
    exp_t e;
    rst_in    = r;
    wd.enable = en;
    wd.kick   = k;
    if (r) begin
      m_st = 0; m_cnt = 0; m_pcnt = 0; m_req = 1'b0; m_trip = 0;
    end else begin
      case (m_st)
        0: if (en) begin m_st = 1; m_cnt = 0; end
        1: begin
          if (!en)              begin m_st = 0; m_cnt = 0; end
          else if (k)           m_cnt = 0;
          else if (m_cnt == T-1) begin
            m_st = 2; m_req = 1'b1; m_pcnt = 0;
            if (m_trip < 255) m_trip++;
          end else              m_cnt++;
        end
        default: begin
          if (m_pcnt == P-1) begin
            m_req = 1'b0; m_cnt = 0; m_st = en ? 1 : 0;
          end else m_pcnt++;
        end
      endcase
    end
    e.req  = m_req;
`ifdef WATCHDOG_WARN_EN
    e.warn = (m_st == 1) && (m_cnt >= T - M);
`else
    e.warn = 1'b0;
`endif
    e.trip = 8'(m_trip);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    tick(1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({wd.rst_req, wd.warn, wd.trip_count} !== {1'b0, 1'b0, 8'd0} ||
        {wd.rst_req, wd.warn, wd.trip_count} !== e) begin
      errors++;
      $display("FAIL reset_state: got req=%b warn=%b trip=%0d, want 0 0 0",
               wd.rst_req, wd.warn, wd.trip_count);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic req_after[0:20];
    tick(1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i <= 20; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      req_after[i] = wd.rst_req;
      checks++;
      if ({wd.rst_req, wd.warn, wd.trip_count} !== e) begin
        errors++;
        $display("FAIL timeout_cycle%0d: got req=%b warn=%b trip=%0d, want req=%b warn=%b trip=%0d",
                 i, wd.rst_req, wd.warn, wd.trip_count, e.req, e.warn, e.trip);
      end
      if (i == 11) begin
        checks++;
        if (wd.trip_count !== 8'd1) begin
          errors++;
          $display("FAIL timeout_trip: got %0d, want 1", wd.trip_count);
        end
      end
    end
    checks++;
    if ({req_after[7], req_after[8], req_after[9], req_after[10], req_after[11],
         req_after[18], req_after[19]} !== 7'b0111001) begin
      errors++;
      $display("FAIL timeout_edges: got e7..e11,e18,e19=%b%b%b%b%b%b%b, want 0111001",
               req_after[7], req_after[8], req_after[9], req_after[10], req_after[11],
               req_after[18], req_after[19]);
    end
  endtask

  task automatic test_kick_period(input int period);
    exp_t e;
    int   req_hi = 0;
    int   warn_hi = 0;
    tick(1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    tick(1'b0, 1'b1, 1'b0); void'(sb.pop_front());
    for (int i = 1; i <= 100; i++) begin
      tick(1'b0, 1'b1, (i % period) == 0);
      e = sb.pop_front();
      if (wd.rst_req === 1'b1) req_hi++;
      if (wd.warn === 1'b1)    warn_hi++;
      checks++;
      if ({wd.rst_req, wd.warn, wd.trip_count} !== e) begin
        errors++;
        $display("FAIL kick%0d_cycle%0d: got req=%b warn=%b trip=%0d, want req=%b warn=%b trip=%0d",
                 period, i, wd.rst_req, wd.warn, wd.trip_count, e.req, e.warn, e.trip);
      end
    end
    checks++;
    if (req_hi != 0 || wd.trip_count !== 8'd0) begin
      errors++;
      $display("FAIL kick%0d_nofire: got req_cycles=%0d trip=%0d, want 0 0",
               period, req_hi, wd.trip_count);
    end
    checks++;
`ifdef WATCHDOG_WARN_EN
    if (warn_hi != ((period == 7) ? 14 : 0)) begin
`else
    if (warn_hi != 0) begin
`endif
      errors++;
      $display("FAIL kick%0d_warn: got warn_cycles=%0d", period, warn_hi);
    end
  endtask

  task automatic test_kick_at_timeout();
    exp_t e;
    logic r8, r15, r16;
    tick(1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    tick(1'b0, 1'b1, 1'b0); void'(sb.pop_front());
    r8 = 1'b0; r15 = 1'b0; r16 = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick(1'b0, 1'b1, i == 8);
      e = sb.pop_front();
      if (i == 8)  r8  = wd.rst_req;
      if (i == 15) r15 = wd.rst_req;
      if (i == 16) r16 = wd.rst_req;
      checks++;
      if ({wd.rst_req, wd.warn, wd.trip_count} !== e) begin
        errors++;
        $display("FAIL lastkick_cycle%0d: got req=%b warn=%b trip=%0d, want req=%b warn=%b trip=%0d",
                 i, wd.rst_req, wd.warn, wd.trip_count, e.req, e.warn, e.trip);
      end
    end
    checks++;
    if ({r8, r15, r16} !== 3'b001) begin
      errors++;
      $display("FAIL lastkick_edges: got e8,e15,e16=%b%b%b, want 001", r8, r15, r16);
    end
  endtask

  task automatic test_enable_drop();
    exp_t e;
    int   req_hi = 0;
    tick(1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    tick(1'b0, 1'b1, 1'b0); void'(sb.pop_front());
    // cnt=5 is sampled at edge 6; drop enable there and stay idle.
    for (int i = 1; i <= 25; i++) begin
      tick(1'b0, i < 6, 1'b0);
      e = sb.pop_front();
      if (wd.rst_req === 1'b1) req_hi++;
      checks++;
      if ({wd.rst_req, wd.warn, wd.trip_count} !== e) begin
        errors++;
        $display("FAIL endrop_idle_cycle%0d: got req=%b warn=%b trip=%0d, want req=%b warn=%b trip=%0d",
                 i, wd.rst_req, wd.warn, wd.trip_count, e.req, e.warn, e.trip);
      end
    end
    checks++;
    if (req_hi != 0) begin
      errors++;
      $display("FAIL endrop_nopulse: got req_cycles=%0d, want 0", req_hi);
    end
    // Re-arm, fire after edge 8, drop enable from edge 9 (first FIRE cycle).
    req_hi = 0;
    tick(1'b0, 1'b1, 1'b0); void'(sb.pop_front());
    for (int i = 1; i <= 24; i++) begin
      tick(1'b0, i < 9, 1'b0);
      e = sb.pop_front();
      if (wd.rst_req === 1'b1) req_hi++;
      checks++;
      if ({wd.rst_req, wd.warn, wd.trip_count} !== e) begin
        errors++;
        $display("FAIL endrop_fire_cycle%0d: got req=%b warn=%b trip=%0d, want req=%b warn=%b trip=%0d",
                 i, wd.rst_req, wd.warn, wd.trip_count, e.req, e.warn, e.trip);
      end
    end
    checks++;
    if (req_hi != P || wd.trip_count !== 8'd1) begin
      errors++;
      $display("FAIL endrop_fullpulse: got req_cycles=%0d trip=%0d, want 3 1",
               req_hi, wd.trip_count);
    end
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    tick(1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    tick(1'b0, 1'b1, 1'b0); void'(sb.pop_front());
    for (int i = 1; i <= 14; i++) begin
      tick(i == 10, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({wd.rst_req, wd.warn, wd.trip_count} !== e) begin
        errors++;
        $display("FAIL midrst_cycle%0d: got req=%b warn=%b trip=%0d, want req=%b warn=%b trip=%0d",
                 i, wd.rst_req, wd.warn, wd.trip_count, e.req, e.warn, e.trip);
      end
      if (i == 10) begin
        checks++;
        if ({wd.rst_req, wd.trip_count} !== {1'b0, 8'd0}) begin
          errors++;
          $display("FAIL midrst_clear: got req=%b trip=%0d, want 0 0",
                   wd.rst_req, wd.trip_count);
        end
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   pulses = 0;
    logic prev = 1'b0;
    tick(1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 300 * (T + P) + 2; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      if (wd.rst_req === 1'b1 && prev !== 1'b1) pulses++;
      prev = wd.rst_req;
      checks++;
      if ({wd.rst_req, wd.warn, wd.trip_count} !== e) begin
        errors++;
        $display("FAIL sat_cycle%0d: got req=%b warn=%b trip=%0d, want req=%b warn=%b trip=%0d",
                 i, wd.rst_req, wd.warn, wd.trip_count, e.req, e.warn, e.trip);
      end
    end
    checks++;
    if (wd.trip_count !== 8'd255 || pulses != 300) begin
      errors++;
      $display("FAIL sat_hold: got trip=%0d pulses=%0d, want 255 300", wd.trip_count, pulses);
    end
  endtask

  initial begin
    rst_in    = 1'b1;
    wd.enable = 1'b0;
    wd.kick   = 1'b0;
    test_reset();
    test_timeout();
    test_kick_period(6);
    test_kick_period(7);
    test_kick_at_timeout();
    test_enable_drop();
    test_reset_mid_pulse();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
